cnt_window_sched: RTL and testbench

Round-robin scheduler that shares one CNT_W-bit interval counter among N_REQ requesters. Each requester asks for a timed window of programmable length. The block grants one requester at a time, runs the counter for that window and pulses a per-requester done flag at the end. It sits between the requesting control FSMs and the shared counter datapath, so only one client owns the counter at any time.

---
 rtl/cnt_sched_pkg.sv | 15 +
 rtl/window_cnt.sv | 40 ++++
 rtl/cnt_window_sched.sv | 141 ++++++++++++++
 tb/tb_cnt_window_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cnt_sched_pkg.sv
// Shared definitions for the counter-window scheduler: FSM encoding and
// default sizing constants used by the top level and its counter.
package cnt_sched_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 8;

  // Explicit encodings keep the state register layout stable across tools.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/window_cnt.sv
// Shared interval counter: holds the terminal count of the current window
// and flags when the running count has reached it.
module window_cnt
  import cnt_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_tc,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             match
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] tc_reg;

  // Load starts a new window from zero; clear only drops the count so the
  // terminal value stays untouched until the next grant reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      tc_reg  <= '0;
    end else if (load) begin
      cnt_reg <= '0;
      tc_reg  <= load_tc;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt   = cnt_reg;
  assign match = (cnt_reg == tc_reg);

endmodule

// File: rtl/cnt_window_sched.sv
// Round-robin owner of a shared interval counter: grants one requester a
// window of its requested length and pulses that requester's done flag at
// the end, or releases the counter early when the requester withdraws.
module cnt_window_sched
  import cnt_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] len,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [CNT_W-1:0]       cnt,
  output logic                   busy,
  output logic                   rdy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W:0]   N_WIDE   = (IDX_W + 1)'(N_REQ);

  state_t             state_reg;
  logic [N_REQ-1:0]   gnt_reg;
  logic [N_REQ-1:0]   done_reg;
  logic [IDX_W-1:0]   last_gnt_reg;

  logic [IDX_W-1:0]   start_idx;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   rot_off;
  logic               rot_found;
  logic [IDX_W:0]     pick_sum;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   pick_onehot;
  logic [CNT_W-1:0]   len_sel;

  logic               grant_fire;
  logic               owner_req;
  logic               abort;
  logic               step;
  logic               match;

  // Rotate requests so the search begins just after the last winner, take
  // the lowest set bit, then map that offset back to an absolute index.
  always_comb begin
    start_idx = (last_gnt_reg == LAST_IDX) ? '0 : last_gnt_reg + IDX_W'(1);
    req_dbl   = {req, req};
    req_rot   = req_dbl[start_idx +: N_REQ];
    rot_off   = '0;
    rot_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!rot_found && req_rot[k]) begin
        rot_off   = IDX_W'(k);
        rot_found = 1'b1;
      end
    end
    pick_sum = {1'b0, start_idx} + {1'b0, rot_off};
    if (pick_sum >= N_WIDE) begin
      pick_sum = pick_sum - N_WIDE;
    end
    pick_idx = pick_sum[IDX_W-1:0];
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
    end
  endgenerate

  // Length of the winning requester, sampled only when the grant is taken.
  assign len_sel = len[pick_idx*CNT_W +: CNT_W];

  assign grant_fire = (state_reg == IDLE) && (|req);
  assign owner_req  = |(req & gnt_reg);
  // Withdrawal is checked ahead of the enable so an abort is honoured even
  // while the count is stalled, and it beats a coincident terminal count.
  assign abort      = (state_reg == RUN) && !owner_req;
  assign step       = (state_reg == RUN) && owner_req && en;

  // tc = len-1 wraps for len=0, giving the full 2^CNT_W window.
  window_cnt #(
    .CNT_W (CNT_W)
  ) u_window_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (abort || (state_reg == DONE)),
    .load    (grant_fire),
    .load_tc (len_sel - CNT_W'(1)),
    .inc     (step),
    .cnt     (cnt),
    .match   (match)
  );

  // Scheduler FSM: grant in IDLE, count in RUN, one-cycle done in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      done_reg     <= '0;
      last_gnt_reg <= LAST_IDX;
    end else begin
      done_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (grant_fire) begin
            state_reg    <= RUN;
            gnt_reg      <= pick_onehot;
            last_gnt_reg <= pick_idx;
          end
        end
        RUN: begin
          if (abort) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
          end else if (step && match) begin
            state_reg <= DONE;
            done_reg  <= gnt_reg;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
        end
      endcase
    end
  end

  assign gnt  = gnt_reg;
  assign done = done_reg;
  assign busy = (state_reg == RUN) || (state_reg == DONE);
  assign rdy  = (state_reg == IDLE);

endmodule

// File: tb/tb_cnt_window_sched.sv
// Directed bench for cnt_window_sched: single window, round-robin order,
// full-length window, enable stall, abort, and asynchronous reset.
module tb_cnt_window_sched;

  localparam int N_REQ = 4;
  localparam int CNT_W = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] len;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic [CNT_W-1:0]       cnt;
  logic                   busy;
  logic                   rdy;

  int errors = 0;
  int checks = 0;

  cnt_window_sched #(
    .N_REQ (N_REQ),
    .CNT_W (CNT_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .done (done),
    .cnt  (cnt),
    .busy (busy),
    .rdy  (rdy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hard bound on total run time.
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_REQ-1:0] exp_g;

    rst = 1'b1; en = 1'b1; req = '0; len = '0;
    step(); step();
    chk("rst_gnt",  32'(gnt),  32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_cnt",  32'(cnt),  32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rdy",  32'(rdy),  32'h1);
    rst = 1'b0;
    step();

    // Single window, len0=3: gnt for 4 cycles, done in the 4th.
    len[0*CNT_W +: CNT_W] = 8'd3;
    req = 4'b0001;
    step();
    chk("w1_gnt0", 32'(gnt), 32'h1);
    chk("w1_cnt0", 32'(cnt), 32'h0);
    chk("w1_busy", 32'(busy), 32'h1);
    chk("w1_rdy",  32'(rdy), 32'h0);
    step();
    chk("w1_cnt1", 32'(cnt), 32'h1);
    step();
    chk("w1_cnt2", 32'(cnt), 32'h2);
    chk("w1_nodone", 32'(done), 32'h0);
    step();
    chk("w1_done", 32'(done), 32'h1);
    chk("w1_gnt3", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();
    chk("w1_idle_gnt",  32'(gnt), 32'h0);
    chk("w1_idle_done", 32'(done), 32'h0);
    chk("w1_idle_rdy",  32'(rdy), 32'h1);
    chk("w1_idle_cnt",  32'(cnt), 32'h0);

    // Round-robin, all len=1; last winner was 0 so order starts at 1.
    len = {4{8'd1}};
    req = 4'b1111;
    exp_g = 4'b0010;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("rr_gnt", 32'(gnt), 32'(exp_g));
      chk("rr_nodone", 32'(done), 32'h0);
      step();
      chk("rr_done", 32'(done), 32'(exp_g));
      step();
      chk("rr_gap", 32'(gnt), 32'h0);
      exp_g = {exp_g[N_REQ-2:0], exp_g[N_REQ-1]};
    end
    req = 4'b0000;

    // Full-length window on requester 2 (len=0 -> 256 cycles).
    len = '0;
    req = 4'b0100;
    step();
    chk("full_gnt", 32'(gnt), 32'h4);
    repeat (255) step();
    chk("full_cnt255", 32'(cnt), 32'd255);
    chk("full_nodone", 32'(done), 32'h0);
    step();
    chk("full_done", 32'(done), 32'h4);
    req = 4'b0000;
    step();
    chk("full_idle", 32'(rdy), 32'h1);

    // Enable stall on requester 1, len=10, 5 stalled cycles at cnt=4.
    len[1*CNT_W +: CNT_W] = 8'd10;
    req = 4'b0010;
    step();
    chk("stall_gnt", 32'(gnt), 32'h2);
    repeat (4) step();
    chk("stall_cnt4", 32'(cnt), 32'd4);
    en = 1'b0;
    repeat (5) step();
    chk("stall_hold", 32'(cnt), 32'd4);
    chk("stall_gnt_held", 32'(gnt), 32'h2);
    en = 1'b1;
    repeat (5) step();
    chk("stall_cnt9", 32'(cnt), 32'd9);
    chk("stall_nodone", 32'(done), 32'h0);
    step();
    chk("stall_done", 32'(done), 32'h2);
    req = 4'b0000;
    step();

    // Abort: requester 1 drops at cnt=2, requester 2 takes over next cycle.
    len[1*CNT_W +: CNT_W] = 8'd8;
    len[2*CNT_W +: CNT_W] = 8'd2;
    req = 4'b0010;
    step();
    chk("ab_gnt", 32'(gnt), 32'h2);
    step(); step();
    chk("ab_cnt2", 32'(cnt), 32'd2);
    req = 4'b0100;
    step();
    chk("ab_gnt0", 32'(gnt), 32'h0);
    chk("ab_nodone", 32'(done), 32'h0);
    chk("ab_rdy", 32'(rdy), 32'h1);
    step();
    chk("ab_regrant", 32'(gnt), 32'h4);
    step();
    step();
    chk("ab_r2_done", 32'(done), 32'h4);
    req = 4'b0000;
    step();

    // Abort coinciding with terminal count (len=1): no done pulse.
    len[0*CNT_W +: CNT_W] = 8'd1;
    req = 4'b0001;
    step();
    chk("abtc_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();
    chk("abtc_nodone", 32'(done), 32'h0);
    chk("abtc_gnt0", 32'(gnt), 32'h0);

    // Reset mid-window at cnt=5, then requester 0 wins the full field.
    len[0*CNT_W +: CNT_W] = 8'd10;
    req = 4'b0001;
    step();
    repeat (5) step();
    chk("mr_cnt5", 32'(cnt), 32'd5);
    rst = 1'b1;
    #1;
    chk("mr_gnt",  32'(gnt),  32'h0);
    chk("mr_cnt",  32'(cnt),  32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_rdy",  32'(rdy),  32'h1);
    chk("mr_done", 32'(done), 32'h0);
    step();
    rst = 1'b0;
    req = 4'b1111;
    step();
    chk("mr_first", 32'(gnt), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
